// File: rtl/toggle_event_rx.sv
// rtl/toggle_event_rx.sv - toggle-link receiver: sync, edge detect, pending queue, ack toggle
// Optional glitch filter on the synchronised level: define TOGGLE_RX_FILTER_EN
module toggle_event_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              t_in,
    input  logic              rd,
    input  logic              clr_ovf,
    output logic              pulse,
    output logic              valid,
    output logic [PEND_W-1:0] pending,
    output logic              ack_t,
    output logic [CNT_W-1:0]  ev_cnt,
    output logic              ovf,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_h;
    logic                   r_pulse;
    logic                   r_valid;
    logic [PEND_W-1:0]      r_pend;
    logic                   r_ack;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    state_t                 r_state;
    state_t                 w_state_next;

    logic              w_s_last;
    logic              w_ev;
    logic              w_take;
    logic              w_acc;
    logic              w_rej;
    logic [PEND_W-1:0] w_pend_next;

    assign w_s_last = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], t_in};
        end
    end

`ifdef TOGGLE_RX_FILTER_EN
    logic r_f;

    // r_h doubles as the filtered level: it only follows s_last once s_last has held for two samples
    assign w_ev = (w_s_last == r_f) && (w_s_last != r_h);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= 1'b0;
            r_h <= 1'b0;
        end else begin
            r_f <= w_s_last;
            if (w_ev) begin
                r_h <= w_s_last;
            end
        end
    end
`else
    assign w_ev = w_s_last ^ r_h;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h <= 1'b0;
        end else begin
            r_h <= w_s_last;
        end
    end
`endif

    // A full queue still accepts when a take frees a slot in the same cycle
    assign w_take      = rd && (r_pend != '0);
    assign w_acc       = w_ev && ((r_pend != PEND_MAX) || rd);
    assign w_rej       = w_ev && !w_acc;
    assign w_pend_next = r_pend + PEND_W'(w_acc) - PEND_W'(w_take);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_state_next = (w_pend_next == PEND_MAX) ? FULL : BUSY;
                end
            end
            BUSY: begin
                if (w_pend_next == PEND_MAX) begin
                    w_state_next = FULL;
                end else if (w_pend_next == '0) begin
                    w_state_next = IDLE;
                end
            end
            FULL: begin
                if (w_pend_next != PEND_MAX) begin
                    w_state_next = (w_pend_next == '0) ? IDLE : BUSY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pulse <= 1'b0;
            r_valid <= 1'b0;
            r_pend  <= '0;
            r_ack   <= 1'b0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pulse <= w_ev;
            r_valid <= (w_state_next != IDLE);
            r_pend  <= w_pend_next;
            if (w_take) begin
                r_ack <= ~r_ack;
            end
            if (w_acc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rej) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pulse   = r_pulse;
    assign valid   = r_valid;
    assign pending = r_pend;
    assign ack_t   = r_ack;
    assign ev_cnt  = r_cnt;
    assign ovf     = r_ovf;
    assign state   = r_state;

endmodule

// File: doc/toggle_event_rx.md
Name: toggle_event_rx

Overview:
- Receiving end of the toggle-signalling link. The transmitter is a T flip-flop whose output q flips once per event.
- This block synchronises the incoming toggle level and converts each level change back into a one-cycle pulse.
- Detected events are queued in a pending counter for a local consumer. Each consumed event is acknowledged by flipping a return toggle, so the link is handshaked in both directions.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on t_in (legal range 2..4).
- PEND_W, 4, pending counter width; the maximum number of outstanding events is PEND_MAX = 2^PEND_W - 1.
- CNT_W, 8, width of the accepted-event counter.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- t_in  input  1  toggle level from the remote transmitter (asynchronous to clk).
- rd  input  1  consumer takes one pending event this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- pulse  output  1  registered one-cycle strobe per detected toggle.
- valid  output  1  pending != 0.
- pending  output  PEND_W  number of outstanding events.
- ack_t  output  1  return toggle; flips once per consumed event.
- ev_cnt  output  CNT_W  accepted events, wraps modulo 2^CNT_W.
- ovf  output  1  sticky: an event was dropped because the queue was full.
- state  output  2  FSM state: 0 IDLE, 1 BUSY, 2 FULL.

Behaviour:
Reset:
- Asserting rst_n low immediately clears every synchroniser flop, the edge-history flop and all outputs: pulse=0, valid=0, pending=0, ack_t=0, ev_cnt=0, ovf=0, state=IDLE.
- Reset mid-operation discards all pending events.
- The link convention is t_in=0 at reset release, matching the transmitter's power-up q=0. If t_in=1 at release, one event is detected.

Synchroniser and edge detect:
- A SYNC_STAGES-deep flop chain samples t_in; s_last is the final stage and h is a history flop loaded from s_last.
- ev = s_last ^ h, a combinational signal.
- If t_in changes before edge k, pulse is high between edges k+SYNC_STAGES and k+SYNC_STAGES+1. With the default this is 3 cycles.
- pending, ev_cnt and state update on the same edge that raises pulse.
- Two t_in changes closer together than one clk period may cancel each other. This is a transmitter constraint and is not checked.

Pending queue and FSM:
- Accept rule: ev is accepted when pending < PEND_MAX, or when pending == PEND_MAX and rd is also high in that cycle.
- Take rule: rd is effective only when pending > 0. When pending == 0, rd is ignored and ack_t does not change.
- Counter update: pending_next = pending + accepted - take. Effective ev and rd in the same cycle leave pending unchanged.
- Every take flips ack_t.
- ev_cnt increments on every accepted event.
- Rejected event (FULL and no rd): the event is dropped, pending stays at PEND_MAX, ev_cnt does not increment, and ovf is set. pulse still fires.
- Overflow clear: clr_ovf clears ovf. If a set and a clear happen in the same cycle, the set wins.
- State transitions:
  - IDLE → BUSY on an accepted event (and to FULL if PEND_MAX == 1).
  - BUSY → FULL when pending_next == PEND_MAX.
  - BUSY → IDLE when pending_next == 0.
  - FULL → BUSY on an effective rd without an accepted event.
  - state always equals the encoding derived from pending: IDLE when 0, FULL when PEND_MAX, BUSY otherwise.
- valid = (state != IDLE), registered.

Optional Feature:
- Macro: TOGGLE_RX_FILTER_EN.
- Defined:
  - An extra flop f follows s_last, and the filtered level changes only when s_last == f for two consecutive cycles.
  - The edge detector operates on the filtered level, which adds 1 cycle of latency (default 4 cycles).
  - Synchronised glitches of one cycle are ignored.
- Undefined: no filter flop; the edge detector works on s_last directly with the latency stated above.

Test Plan:
- Reset, then toggle t_in 0→1 between edges; rd=0 → pulse exactly 1 cycle, 3 edges later; pending=1, valid=1, state=BUSY, ev_cnt=1.
- 15 toggles spaced 4 cycles apart, rd=0 → pending=15, state=FULL, ovf=0. A 16th toggle → pulse=1, pending=15, ev_cnt=15, ovf=1. clr_ovf=1 → ovf=0.
- pending=3, rd held 4 cycles → pending 2,1,0,0; ack_t flips 3 times only; state IDLE; the 4th rd has no effect.
- pending=15 (FULL), rd coincident with an ev cycle → pending stays 15, ev_cnt+1, ack_t flips, ovf stays 0. Same test at pending=5 → pending stays 5.
- Reset asserted with pending=7 and a toggle in flight → all outputs 0 immediately. After release with t_in=0, no spurious pulse.
- With TOGGLE_RX_FILTER_EN: a 1-cycle t_in glitch (0→1→0) → no pulse and pending unchanged. A stable toggle → pulse 4 edges later.
